taxi_mileage_counter: RTL

- Producer end of the meter-count interface into the mileage display block.
- Conditions the raw wheel-sensor pulse: 2-flop synchroniser plus debounce.
- Accumulates travelled metres per trip under an IDLE/RUN/PAUSE trip state machine.
- Flags the "waiting" condition (cab stationary while a trip is running) for the fare logic.

---
 rtl/taxi_pkg.sv | 13 +
 rtl/taxi_pulse_debounce.sv | 51 +++++
 rtl/taxi_mileage_counter.sv | 107 ++++++++++
 3 files changed

// File: rtl/taxi_pkg.sv
// Shared types and constants for the taxi mileage counter.
package taxi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } trip_state_t;

  localparam int METERS_W       = 20;
  localparam int MAX_METERS_DEF = 99999;

endpackage

// File: rtl/taxi_pulse_debounce.sv
// Wheel-sensor conditioning: 2-flop synchroniser, stability debounce and
// a one-cycle count_evt on each filtered 0->1 transition.
module taxi_pulse_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wheel_pulse,
  output logic count_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // count_evt is combinational so the accumulator updates on the same edge
  // that filt rises.
  always_comb begin
    s1_d      = wheel_pulse;
    s2_d      = s1_q;
    filt_d    = filt_q;
    cnt_d     = '0;
    count_evt = 1'b0;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d    = s2_q;
        count_evt = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/taxi_mileage_counter.sv
// Trip state machine, saturating metre accumulator and waiting detector
// driven by the debounced wheel pulse.
module taxi_mileage_counter
  import taxi_pkg::*;
#(
  parameter int M_PER_PULSE     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_CYCLES     = 1000,
  parameter int MAX_METERS      = MAX_METERS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wheel_pulse,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  output logic [METERS_W-1:0] meters,
  output logic                running,
  output logic                waiting,
  output logic                sat
);

  localparam int IDLE_W = $clog2(WAIT_CYCLES + 1);

  logic count_evt;

  taxi_pulse_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .wheel_pulse(wheel_pulse),
    .count_evt  (count_evt)
  );

  trip_state_t         state_q, state_d;
  logic [METERS_W-1:0] meters_q, meters_d;
  logic                sat_q, sat_d;
  logic                running_q, running_d;
  logic                waiting_q, waiting_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [METERS_W:0]   sum;

  assign sum = {1'b0, meters_q} + (METERS_W + 1)'(M_PER_PULSE);

  // Control requests take priority over a coincident count event, which is dropped.
  always_comb begin
    state_d  = state_q;
    meters_d = meters_q;
    sat_d    = sat_q;
    if (clr) begin
      state_d  = IDLE;
      meters_d = '0;
      sat_d    = 1'b0;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      state_d  = RUN;
      meters_d = '0;
      sat_d    = 1'b0;
    end else if (state_q == RUN && count_evt) begin
      if (sum > (METERS_W + 1)'(MAX_METERS)) begin
        meters_d = METERS_W'(MAX_METERS);
        sat_d    = 1'b1;
      end else begin
        meters_d = sum[METERS_W-1:0];
      end
    end
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_d != RUN) begin
      idle_cnt_d = '0;
    end else if (state_q != RUN || start || count_evt) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q < IDLE_W'(WAIT_CYCLES)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
    running_d = (state_d == RUN);
    waiting_d = (state_d == RUN) && (idle_cnt_d == IDLE_W'(WAIT_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      meters_q   <= '0;
      sat_q      <= 1'b0;
      running_q  <= 1'b0;
      waiting_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      meters_q   <= meters_d;
      sat_q      <= sat_d;
      running_q  <= running_d;
      waiting_q  <= waiting_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign meters  = meters_q;
  assign running = running_q;
  assign waiting = waiting_q;
  assign sat     = sat_q;

endmodule
